// File: rtl/agu_issue_queue.sv
// rtl/agu_issue_queue.sv - register-group request queue and issuer in front of the vector AGU
//
// Purpose: accepts {base register, vlmul} requests from decode, drops illegal
// encodings (reserved vlmul, misaligned group base) with a one-cycle err pulse,
// buffers legal ones in a DEPTH-entry FIFO and issues them one at a time to the
// AGU, only while the AGU reports idle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_ready        decode request handshake
//   in_addr, in_vlmul        request payload
//   agu_en                   one-cycle issue strobe
//   agu_addr, agu_vlmul      issued payload, held until the next issue
//   agu_idle                 AGU idle status
//   err                      one-cycle pulse per dropped request
//   count                    FIFO occupancy
//   busy                     queue, issuer or AGU still has work

module agu_issue_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [2:0]              in_vlmul,
    output logic                    agu_en,
    output logic [ADDR_WIDTH-1:0]   agu_addr,
    output logic [2:0]              agu_vlmul,
    input  logic                    agu_idle,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_WIDTH + 3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [ENT_W-1:0]        mem [DEPTH];
    logic [ENT_W-1:0]        head;

    logic                    req_legal;
    logic [2:0]              req_vlmul;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic                    push;
    logic                    wr_en;
    logic                    drop;
    logic                    issue;

    // Classification: fractional LMUL occupies one register, so it is queued
    // as vlmul 000; integer LMUL needs the base aligned to the group size.
    always_comb begin
        req_legal  = 1'b1;
        req_vlmul  = in_vlmul;
        align_mask = '0;
        case (in_vlmul)
            3'b000:  align_mask = '0;
            3'b001:  align_mask = ADDR_WIDTH'(1);
            3'b010:  align_mask = ADDR_WIDTH'(3);
            3'b011:  align_mask = ADDR_WIDTH'(7);
            3'b100:  req_legal  = 1'b0;
            default: req_vlmul  = 3'b000;
        endcase
        if ((in_addr & align_mask) != '0) begin
            req_legal = 1'b0;
        end
    end

    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign wr_en    = push && req_legal;
    assign drop     = push && !req_legal;
    assign head     = mem[rd_ptr];
    assign busy     = (count != '0) || (state_q != S_IDLE) || !agu_idle;

    // Storage needs no reset: entries are discarded by resetting the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_addr, req_vlmul};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issuer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issuer next state: after an issue, wait until the AGU has visibly gone
    // busy so the stale idle level is never mistaken for readiness.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue)     state_d = S_WAIT;
            S_WAIT:  if (!agu_idle) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Issuer output decode
    always_comb begin
        issue = (state_q == S_IDLE) && (count != '0) && agu_idle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            agu_en    <= 1'b0;
            agu_addr  <= '0;
            agu_vlmul <= 3'b000;
            err       <= 1'b0;
        end else begin
            agu_en <= issue;
            err    <= drop;
            if (issue) begin
                agu_addr  <= head[ENT_W-1:3];
                agu_vlmul <= head[2:0];
            end
        end
    end

endmodule

// File: tb/tb_agu_issue_queue.sv
// tb/tb_agu_issue_queue.sv - scoreboard bench for agu_issue_queue

module tb_agu_issue_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_addr;
    logic [2:0] in_vlmul;
    logic       agu_en;
    logic [4:0] agu_addr;
    logic [2:0] agu_vlmul;
    logic       agu_idle;
    logic       err;
    logic [2:0] count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         err_pend = 0;

    // AGU model: captures on en && idle, then busy for 2^vlmul cycles
    int   agu_rem = 0;
    logic agu_hold = 1'b0;
    assign agu_idle = (agu_rem == 0) && !agu_hold;

    int cyc = 0;
    int last_cyc = 0;
    int last_need = 0;
    bit have_last = 1'b0;

    always #5 clk = ~clk;

    agu_issue_queue #(.ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_vlmul  (in_vlmul),
        .agu_en    (agu_en),
        .agu_addr  (agu_addr),
        .agu_vlmul (agu_vlmul),
        .agu_idle  (agu_idle),
        .err       (err),
        .count     (count),
        .busy      (busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (agu_en && agu_idle) begin
            agu_rem <= 1 << agu_vlmul;
        end else if (agu_rem > 0) begin
            agu_rem <= agu_rem - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues or flags an error
    always @(negedge clk) begin
        logic [7:0] e;
        if (agu_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got addr %0h vlmul %0h with nothing expected", agu_addr, agu_vlmul);
            end else begin
                e = exp_q.pop_front();
                check("issue_addr", 32'(agu_addr), 32'(e[7:3]));
                check("issue_vlmul", 32'(agu_vlmul), 32'(e[2:0]));
            end
            if (have_last) begin
                check("issue_spacing_ok", 32'(cyc - last_cyc >= last_need), 32'd1);
            end
            have_last = 1'b1;
            last_cyc  = cyc;
            last_need = (1 << agu_vlmul) + 2;
        end
        if (err) begin
            if (err_pend == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got err=1 expected err=0");
            end else begin
                checks++;
                err_pend--;
            end
        end
    end

    // Called at a negedge; presents one request for one edge.
    task automatic push(input logic [4:0] a, input logic [2:0] v,
                        input bit exp_acc, input bit exp_drop, input logic [2:0] exp_v);
        in_valid = 1'b1;
        in_addr  = a;
        in_vlmul = v;
        check("in_ready_before_push", 32'(in_ready), 32'(exp_acc));
        if (exp_acc) begin
            if (exp_drop) err_pend++;
            else          exp_q.push_back({a, exp_v});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_vlmul = '0;
        #2;
        check("reset_count", 32'(count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_agu_en", 32'(agu_en), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single legal request: issue exactly two edges after the push
        push(5'h01, 3'b000, 1'b1, 1'b0, 3'b000);
        check("latency_not_early", 32'(agu_en), 32'd0);
        check("count_after_push", 32'(count), 32'd1);
        @(negedge clk);
        check("latency_issue", 32'(agu_en), 32'd1);
        repeat (5) @(negedge clk);
        check("count_drained", 32'(count), 32'd0);

        // Misaligned group base
        push(5'h03, 3'b001, 1'b1, 1'b1, 3'b000);
        repeat (4) @(negedge clk);
        check("count_after_misaligned", 32'(count), 32'd0);

        // Reserved vlmul
        push(5'h05, 3'b100, 1'b1, 1'b1, 3'b000);
        repeat (4) @(negedge clk);
        check("count_after_reserved", 32'(count), 32'd0);

        // Fractional vlmul issues as a single register
        push(5'h05, 3'b110, 1'b1, 1'b0, 3'b000);
        repeat (8) @(negedge clk);

        // Fill while the AGU is held busy; the fifth request is refused
        agu_hold = 1'b1;
        push(5'h02, 3'b001, 1'b1, 1'b0, 3'b001);
        push(5'h04, 3'b010, 1'b1, 1'b0, 3'b010);
        push(5'h08, 3'b011, 1'b1, 1'b0, 3'b011);
        push(5'h06, 3'b000, 1'b1, 1'b0, 3'b000);
        check("count_full", 32'(count), 32'd4);
        push(5'h09, 3'b000, 1'b0, 1'b0, 3'b000);
        check("count_still_full", 32'(count), 32'd4);
        agu_hold = 1'b0;
        repeat (60) @(negedge clk);
        check("count_after_drain", 32'(count), 32'd0);
        check("busy_after_drain", 32'(busy), 32'd0);

        // Push on the same edge as an issue pop
        agu_hold = 1'b1;
        push(5'h0a, 3'b000, 1'b1, 1'b0, 3'b000);
        push(5'h0c, 3'b000, 1'b1, 1'b0, 3'b000);
        check("count_two", 32'(count), 32'd2);
        agu_hold = 1'b0;
        push(5'h0e, 3'b000, 1'b1, 1'b0, 3'b000);
        check("count_push_pop", 32'(count), 32'd2);

        // Asynchronous reset while waiting on the AGU
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_agu_en", 32'(agu_en), 32'd0);
        check("async_agu_addr", 32'(agu_addr), 32'd0);
        check("async_agu_vlmul", 32'(agu_vlmul), 32'd0);
        check("async_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("no_issue_after_reset", 32'(exp_q.size()), 32'd0);

        // A fresh push still flows after reset
        push(5'h10, 3'b010, 1'b1, 1'b0, 3'b010);
        repeat (12) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_err_pending", 32'(err_pend), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/agu_issue_queue.md
# agu_issue_queue

Request buffer and issuer directly upstream of the vector address generation unit (`addr_gen_unit`). Accepts register-group requests (base vector register address plus `vlmul`) from the decode stage through a valid/ready handshake. Screens them for illegal encodings, queues legal ones in a small FIFO, and hands them one at a time to the AGU. A new request is issued only when the AGU reports idle, so the AGU never sees a request while busy.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, width of a vector register address; must match the AGU.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = in reset).
- `in_valid`  in  1  decode presents a request.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `in_addr`  in  ADDR_WIDTH  base register of the group.
- `in_vlmul`  in  3  RVV `vlmul` encoding.
- `agu_en`  out  1  one-cycle issue strobe to the AGU `en`.
- `agu_addr`  out  ADDR_WIDTH  to AGU `addr_in`; held stable after issue.
- `agu_vlmul`  out  3  to AGU `vlmul`; held stable after issue.
- `agu_idle`  in  1  AGU `idle`.
- `err`  out  1  one-cycle pulse: the request just accepted was dropped as illegal.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  `count != 0 || state != S_IDLE || !agu_idle`.

## Operation
- Push on any edge with `in_valid && in_ready`. The request is classified on the same edge:
  - `vlmul` 3'b100: reserved. Dropped, `err` = 1 next cycle.
  - `vlmul` 3'b101/110/111 (fractional): legal. Enqueued with `vlmul` forced to 3'b000, since it occupies one register.
  - `vlmul` 3'b000–011: legal only if `in_addr` is a multiple of 2^vlmul, i.e. the low `vlmul` bits are zero. Otherwise dropped, `err` = 1 next cycle.
  - A dropped request still completes the handshake, consumes no FIFO slot, and leaves `count` unchanged.
- FIFO: `DEPTH` entries of {addr, vlmul}.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is tracked separately.
  - `in_ready` depends only on `count`. When full, no push is accepted even if a pop occurs on the same edge.
  - When not full, a simultaneous push and pop is allowed and leaves `count` unchanged.
- State machine:
  - `S_IDLE`: if `count != 0 && agu_idle`, pop the head, load `agu_addr`/`agu_vlmul`, set `agu_en` = 1, and go to `S_WAIT`.
  - `S_WAIT`: `agu_en` cleared on the first edge. Stay until `agu_idle` is sampled 0, then go to `S_IDLE`.
  - `S_IDLE` issues again only after `agu_idle` has returned to 1.
- Contract with the AGU: it captures `addr_in`/`vlmul` on the edge where `en && idle`, then drives `idle` = 0 for 2^vlmul cycles (at least 1).

## Timing
- Reset (`rst` = 0), immediately and asynchronously:
  - `count` = 0, `in_ready` = 1, `agu_en` = 0.
  - `agu_addr` = 0, `agu_vlmul` = 0, `err` = 0.
  - State = `S_IDLE`, pointers = 0.
  - Queued entries are discarded.
  - Reset mid-issue leaves the AGU's own reset to clear it.
- Push-to-issue latency with an empty queue and idle AGU:
  - Push on edge k; `agu_en` high during the cycle after edge k+1.
  - That is 2 edges; no bypass path.
- `agu_en` is high for exactly one cycle per issued request. `agu_addr`/`agu_vlmul` change only on issue edges.
- `err` is registered and high for exactly one cycle per dropped request.
- Back-to-back issue spacing ≥ AGU busy time + 2 cycles.
- All outputs are registered except `in_ready` and `busy`, which are combinational from registers and `agu_idle`.

## Test plan
- Reset, then push {addr=5'h1, vlmul=3'b000} with `agu_idle` = 1:
  - `agu_en` pulses once, 2 edges after the push, with `agu_addr` = 1, `agu_vlmul` = 0.
  - `count` returns to 0.
- Push {5'h3, 3'b001}:
  - Dropped as misaligned; `err` pulses once; `count` stays 0; no `agu_en`.
- Push {5'h5, 3'b100}: dropped as reserved, `err` = 1 for one cycle.
- Push {5'h5, 3'b110}: issued with `agu_vlmul` = 3'b000.
- Hold `agu_idle` = 0 and push 5 legal requests with `DEPTH` = 4:
  - 4 accepted, `in_ready` = 0, `count` = 4.
  - Release `agu_idle`: the 4 requests issue in FIFO order, one per AGU busy period.
- With the queue at 2 entries, push on the same edge as an issue pop: `count` stays 2. Then assert `rst` = 0 mid-`S_WAIT`:
  - All outputs reach reset values without a clock edge.
  - No further `agu_en` follows deassertion until a new push.
